// File: rtl/pipeline_adder_hs.sv
// pipeline_adder_hs: carry-segmented pipelined adder with valid/ready
// handshake, pause and flush. Each stage adds one CHUNK of the operands using
// the carry registered by the previous stage, so the longest carry path is
// CHUNK+1 bits. The final stage drives sum/cout/out_valid straight from
// registers.
// Optional build macro: PIPE_ADDER_SUB_EN adds a per-operation 'sub' input
// (sum = a - b, cout = 1 means no borrow). Without it the block always adds.
module pipeline_adder_hs #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pause,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CHUNK = WIDTH / STAGES;

   // Per-stage registers. r_opa/r_opb hold the operand chunks not yet
   // consumed, shifted down so the next chunk to add sits at the LSBs.
   logic             r_valid [STAGES];
   logic             r_carry [STAGES];
   logic [WIDTH-1:0] r_sum   [STAGES];
   logic [WIDTH-1:0] r_opa   [STAGES];
   logic [WIDTH-1:0] r_opb   [STAGES];

   // Per-stage next-state wires
   logic             w_valid_in  [STAGES];
   logic [CHUNK-1:0] w_chunk_a   [STAGES];
   logic [CHUNK-1:0] w_chunk_b   [STAGES];
   logic             w_cin_stage [STAGES];
   logic [WIDTH-1:0] w_sum_low   [STAGES];
   logic [WIDTH-1:0] w_rem_a     [STAGES];
   logic [WIDTH-1:0] w_rem_b     [STAGES];
   logic [CHUNK:0]   w_add       [STAGES];
   logic [WIDTH-1:0] w_sum_next  [STAGES];

   logic             w_adv;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin_eff;

   // Subtraction is a + ~b + 1, so only stage 0's inputs change.
`ifdef PIPE_ADDER_SUB_EN
   assign w_b_eff   = sub ? ~b : b;
   assign w_cin_eff = sub ? 1'b1 : cin;
`else
   assign w_b_eff   = b;
   assign w_cin_eff = cin;
`endif

   // The whole pipeline moves as one; bubbles are not collapsed.
   assign w_adv     = rst_n & ~pause & ~flush & (~out_valid | out_ready);
   assign in_ready  = w_adv;

   assign out_valid = r_valid[STAGES-1];
   assign sum       = r_sum[STAGES-1];
   assign cout      = r_carry[STAGES-1];

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign w_valid_in[gi]  = in_valid;
            assign w_chunk_a[gi]   = a[CHUNK-1:0];
            assign w_chunk_b[gi]   = w_b_eff[CHUNK-1:0];
            assign w_cin_stage[gi] = w_cin_eff;
            assign w_sum_low[gi]   = '0;
            assign w_rem_a[gi]     = a >> CHUNK;
            assign w_rem_b[gi]     = w_b_eff >> CHUNK;
         end else begin : g_next
            assign w_valid_in[gi]  = r_valid[gi-1];
            assign w_chunk_a[gi]   = r_opa[gi-1][CHUNK-1:0];
            assign w_chunk_b[gi]   = r_opb[gi-1][CHUNK-1:0];
            assign w_cin_stage[gi] = r_carry[gi-1];
            assign w_sum_low[gi]   = r_sum[gi-1];
            assign w_rem_a[gi]     = r_opa[gi-1] >> CHUNK;
            assign w_rem_b[gi]     = r_opb[gi-1] >> CHUNK;
         end
         // One CHUNK+1 bit add per stage; its MSB is the only carry path.
         assign w_add[gi]      = {1'b0, w_chunk_a[gi]} + {1'b0, w_chunk_b[gi]}
                               + {{CHUNK{1'b0}}, w_cin_stage[gi]};
         assign w_sum_next[gi] = w_sum_low[gi]
                               | (WIDTH'(w_add[gi][CHUNK-1:0]) << (gi * CHUNK));
      end
   endgenerate

   // Pipeline registers: async reset, flush clears, otherwise shift on advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            r_valid[k] <= 1'b0;
            r_carry[k] <= 1'b0;
            r_sum[k]   <= '0;
            r_opa[k]   <= '0;
            r_opb[k]   <= '0;
         end
      end else if (flush) begin
         for (int k = 0; k < STAGES; k++) begin
            r_valid[k] <= 1'b0;
            r_carry[k] <= 1'b0;
            r_sum[k]   <= '0;
            r_opa[k]   <= '0;
            r_opb[k]   <= '0;
         end
      end else if (w_adv) begin
         for (int k = 0; k < STAGES; k++) begin
            r_valid[k] <= w_valid_in[k];
            // Bubbles carry zero data so an idle output reads as zero.
            r_carry[k] <= w_valid_in[k] ? w_add[k][CHUNK] : 1'b0;
            r_sum[k]   <= w_valid_in[k] ? w_sum_next[k]   : '0;
            r_opa[k]   <= w_valid_in[k] ? w_rem_a[k]      : '0;
            r_opb[k]   <= w_valid_in[k] ? w_rem_b[k]      : '0;
         end
      end
   end

endmodule
